// File: rtl/fp_unit_arbiter.sv
//------------------------------------------------------------------------------
// fp_unit_arbiter
//
// Shares one single-precision FP core among NREQ requesters. A round-robin
// search picks a winner, its operand pair is latched into fpA/fpB and startFP
// is pulsed. After doneFP the result is registered on outBus and handed to the
// owning requester over a 4-phase resultReady/resultAccepted handshake.
//
// Optional build macro:
//   FPARB_TIMEOUT_EN : adds a WAIT-state watchdog and the timeoutErr output.
//                      On expiry the operation completes with a quiet NaN.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous active-high reset
//   req            per-requester valid operand pair
//   opA, opB       packed operands, requester i at [i*W +: W]
//   grant          one-hot, one-cycle capture acknowledge
//   startFP        one-cycle start pulse to the FP core
//   fpA, fpB       registered operands to the core
//   doneFP         core completion strobe
//   resultFP       core result, valid with doneFP
//   resultReady    one-hot result-valid to the owning requester
//   resultAccepted per-requester result acknowledge
//   outBus         registered result
//   busy           high whenever the FSM is not IDLE
//   timeoutErr     (FPARB_TIMEOUT_EN only) watchdog expired on last operation
//------------------------------------------------------------------------------
module fp_unit_arbiter #(
   parameter int NREQ           = 2,
   parameter int W              = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] opA,
   input  logic [NREQ*W-1:0] opB,
   output logic [NREQ-1:0]   grant,
   output logic              startFP,
   output logic [W-1:0]      fpA,
   output logic [W-1:0]      fpB,
   input  logic              doneFP,
   input  logic [W-1:0]      resultFP,
   output logic [NREQ-1:0]   resultReady,
   input  logic [NREQ-1:0]   resultAccepted,
   output logic [W-1:0]      outBus,
   output logic              busy
`ifdef FPARB_TIMEOUT_EN
   ,
   output logic              timeoutErr
`endif
);

   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW1 = PW + 1;

   // Elaboration-time parameter sanity.
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("fp_unit_arbiter: NREQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("fp_unit_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      WAIT    = 3'd2,
      DELIVER = 3'd3,
      FINISH  = 3'd4
   } state_t;

   state_t          state_r;
   logic [PW-1:0]   ptr_r;
   logic [PW-1:0]   owner_r;
   logic [PW-1:0]   winner_s;
   logic            found_s;
   logic [NREQ-1:0] winner_onehot_s;
   logic [NREQ-1:0] owner_onehot_s;

`ifdef FPARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] QNAN = W'(32'h7FC0_0000);
   logic [CW-1:0]   wait_cnt_r;
   logic            expire_s;
`endif

   // Round-robin search: first set req at or above ptr_r, wrapping modulo NREQ.
   always_comb begin
      logic [PW1-1:0] sum;
      logic [PW-1:0]  idx;
      logic           hit;
      winner_s = ptr_r;
      found_s  = 1'b0;
      sum      = {PW1{1'b0}};
      idx      = {PW{1'b0}};
      hit      = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         sum      = {1'b0, ptr_r} + PW1'(i);
         idx      = (sum >= PW1'(NREQ)) ? PW'(sum - PW1'(NREQ)) : PW'(sum);
         hit      = !found_s && req[idx];
         winner_s = hit ? idx : winner_s;
         found_s  = found_s | req[idx];
      end
   end

   // One-hot decodes of the search winner and the current owner.
   always_comb begin
      winner_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
      owner_onehot_s  = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
   end

`ifdef FPARB_TIMEOUT_EN
   // Watchdog fires on the last allowed WAIT cycle.
   always_comb begin
      expire_s = (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1));
   end
`endif

   // Arbitration FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= {PW{1'b0}};
         owner_r     <= {PW{1'b0}};
         grant       <= {NREQ{1'b0}};
         startFP     <= 1'b0;
         fpA         <= {W{1'b0}};
         fpB         <= {W{1'b0}};
         resultReady <= {NREQ{1'b0}};
         outBus      <= {W{1'b0}};
         busy        <= 1'b0;
`ifdef FPARB_TIMEOUT_EN
         wait_cnt_r  <= {CW{1'b0}};
         timeoutErr  <= 1'b0;
`endif
      end else begin
         // grant and startFP are single-cycle pulses.
         grant   <= {NREQ{1'b0}};
         startFP <= 1'b0;
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  fpA     <= opA[int'(winner_s)*W +: W];
                  fpB     <= opB[int'(winner_s)*W +: W];
                  owner_r <= winner_s;
                  // Pointer moves only on capture, giving strict rotation.
                  ptr_r   <= (winner_s == PW'(NREQ - 1)) ? {PW{1'b0}}
                                                         : winner_s + PW'(1);
                  grant   <= winner_onehot_s;
                  startFP <= 1'b1;
                  busy    <= 1'b1;
                  state_r <= START;
`ifdef FPARB_TIMEOUT_EN
                  wait_cnt_r <= {CW{1'b0}};
                  timeoutErr <= 1'b0;
`endif
               end
            end
            START: begin
               // A core that finishes in the start cycle is accepted directly.
               if (doneFP) begin
                  outBus      <= resultFP;
                  resultReady <= owner_onehot_s;
                  state_r     <= DELIVER;
               end else begin
                  state_r     <= WAIT;
               end
            end
            WAIT: begin
               if (doneFP) begin
                  outBus      <= resultFP;
                  resultReady <= owner_onehot_s;
                  state_r     <= DELIVER;
`ifdef FPARB_TIMEOUT_EN
               end else if (expire_s) begin
                  outBus      <= QNAN;
                  timeoutErr  <= 1'b1;
                  resultReady <= owner_onehot_s;
                  state_r     <= DELIVER;
               end else begin
                  wait_cnt_r  <= wait_cnt_r + CW'(1);
`endif
               end
            end
            DELIVER: begin
               // Only the owner's acknowledge is honoured.
               if (resultAccepted[owner_r]) begin
                  resultReady <= {NREQ{1'b0}};
                  state_r     <= FINISH;
               end
            end
            FINISH: begin
               if (!resultAccepted[owner_r]) begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               resultReady <= {NREQ{1'b0}};
               busy        <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
//------------------------------------------------------------------------------
// tb_fp_unit_arbiter
//
// Directed self-checking bench for fp_unit_arbiter (NREQ=2, W=32). Inputs are
// driven and outputs sampled 1 ns after each rising edge. A negedge monitor
// logs every grant so arbitration order can be checked per scenario.
//------------------------------------------------------------------------------
module tb_fp_unit_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [63:0] opA = 64'h0;
   logic [63:0] opB = 64'h0;
   logic [1:0]  grant;
   logic        startFP;
   logic [31:0] fpA;
   logic [31:0] fpB;
   logic        doneFP = 1'b0;
   logic [31:0] resultFP = 32'h0;
   logic [1:0]  resultReady;
   logic [1:0]  resultAccepted = 2'b00;
   logic [31:0] outBus;
   logic        busy;
`ifdef FPARB_TIMEOUT_EN
   logic        timeoutErr;
`endif

   int total = 0;
   int bad   = 0;
   logic [1:0] glog[$];

   fp_unit_arbiter #(.NREQ(2), .W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .req(req), .opA(opA), .opB(opB),
      .grant(grant), .startFP(startFP), .fpA(fpA), .fpB(fpB),
      .doneFP(doneFP), .resultFP(resultFP), .resultReady(resultReady),
      .resultAccepted(resultAccepted), .outBus(outBus), .busy(busy)
`ifdef FPARB_TIMEOUT_EN
      , .timeoutErr(timeoutErr)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (grant !== 2'b00) glog.push_back(grant);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; req = 2'b00; doneFP = 1'b0; resultAccepted = 2'b00;
      tick; tick;
      rst = 1'b0;
      glog.delete();
   endtask

   // From START: core completes next cycle, owner accepts, handshake closes.
   task automatic finish_op(input logic [1:0] acc, input logic [31:0] res);
      tick;
      doneFP = 1'b1; resultFP = res;
      tick;
      doneFP = 1'b0; resultAccepted = acc;
      tick;
      resultAccepted = 2'b00;
      tick;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", grant); end
      total++; if (startFP !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", startFP); end
      total++; if (resultReady !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", resultReady); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (fpA !== 32'h0 || fpB !== 32'h0) begin bad++; $display("FAIL rst_ops got=%h/%h exp=0/0", fpA, fpB); end
      total++; if (outBus !== 32'h0) begin bad++; $display("FAIL rst_outbus got=%h exp=0", outBus); end
`ifdef FPARB_TIMEOUT_EN
      total++; if (timeoutErr !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeoutErr); end
`endif
      rst = 1'b0;
      tick;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single;
      do_reset;
      opA = {32'hAAAA_AAAA, 32'h3F80_0000};
      opB = {32'h5555_5555, 32'h4000_0000};
      req = 2'b01;
      tick;
      total++; if (grant !== 2'b01) begin bad++; $display("FAIL t1_grant got=%b exp=01", grant); end
      total++; if (startFP !== 1'b1) begin bad++; $display("FAIL t1_start got=%b exp=1", startFP); end
      total++; if (fpA !== 32'h3F80_0000) begin bad++; $display("FAIL t1_fpA got=%h exp=3f800000", fpA); end
      total++; if (fpB !== 32'h4000_0000) begin bad++; $display("FAIL t1_fpB got=%h exp=40000000", fpB); end
      req = 2'b00;
      tick;
      total++; if (grant !== 2'b00 || startFP !== 1'b0) begin bad++; $display("FAIL t1_pulse got=%b/%b exp=00/0", grant, startFP); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b exp=1", busy); end
      tick;
      tick;
      total++; if (resultReady !== 2'b00) begin bad++; $display("FAIL t1_early_ready got=%b exp=00", resultReady); end
      doneFP = 1'b1; resultFP = 32'h4040_0000;
      tick;
      doneFP = 1'b0; resultFP = 32'h0;
      total++; if (resultReady !== 2'b01) begin bad++; $display("FAIL t1_ready got=%b exp=01", resultReady); end
      total++; if (outBus !== 32'h4040_0000) begin bad++; $display("FAIL t1_outbus got=%h exp=40400000", outBus); end
      tick;
      total++; if (resultReady !== 2'b01) begin bad++; $display("FAIL t1_ready_hold got=%b exp=01", resultReady); end
      resultAccepted = 2'b01;
      tick;
      total++; if (resultReady !== 2'b00) begin bad++; $display("FAIL t1_ready_drop got=%b exp=00", resultReady); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_finish_busy got=%b exp=1", busy); end
      resultAccepted = 2'b00;
      tick;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_idle_busy got=%b exp=0", busy); end
      total++; if (outBus !== 32'h4040_0000) begin bad++; $display("FAIL t1_outbus_hold got=%h exp=40400000", outBus); end
   endtask

   task automatic test_simultaneous;
      do_reset;
      opA = {32'h4100_0000, 32'h3F80_0000};
      opB = {32'h4120_0000, 32'h4000_0000};
      req = 2'b11;
      tick;
      total++; if (grant !== 2'b01) begin bad++; $display("FAIL t2_first got=%b exp=01", grant); end
      req = 2'b10;
      finish_op(2'b01, 32'h4040_0000);
      tick;
      total++; if (grant !== 2'b10) begin bad++; $display("FAIL t2_second got=%b exp=10", grant); end
      total++; if (fpA !== 32'h4100_0000 || fpB !== 32'h4120_0000) begin bad++; $display("FAIL t2_ops got=%h/%h exp=41000000/41200000", fpA, fpB); end
      req = 2'b00;
      finish_op(2'b10, 32'h4190_0000);
      total++; if (glog.size() !== 2) begin bad++; $display("FAIL t2_log_len got=%0d exp=2", glog.size()); end
      else if (glog[0] !== 2'b01 || glog[1] !== 2'b10) begin bad++; $display("FAIL t2_order got=%b,%b exp=01,10", glog[0], glog[1]); end
      total++; if (outBus !== 32'h4190_0000) begin bad++; $display("FAIL t2_outbus got=%h exp=41900000", outBus); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] res;
      do_reset;
      req = 2'b11;
      res = 32'h0;
      for (int k = 0; k < 4; k++) begin
         tick;
         res = 32'h4000_0000 + 32'(k);
         finish_op((k % 2 == 1) ? 2'b10 : 2'b01, res);
      end
      req = 2'b00;
      total++; if (glog.size() !== 4) begin bad++; $display("FAIL t3_log_len got=%0d exp=4", glog.size()); end
      else if (glog[0] !== 2'b01 || glog[1] !== 2'b10 || glog[2] !== 2'b01 || glog[3] !== 2'b10)
         begin bad++; $display("FAIL t3_order got=%b,%b,%b,%b exp=01,10,01,10", glog[0], glog[1], glog[2], glog[3]); end
      total++; if (outBus !== 32'h4000_0003) begin bad++; $display("FAIL t3_outbus got=%h exp=40000003", outBus); end
   endtask

   task automatic test_finish_hold;
      do_reset;
      opA = {32'h40A0_0000, 32'h0};
      opB = {32'h3F00_0000, 32'h0};
      req = 2'b10;
      tick;
      total++; if (grant !== 2'b10) begin bad++; $display("FAIL t4_grant got=%b exp=10", grant); end
      total++; if (fpA !== 32'h40A0_0000) begin bad++; $display("FAIL t4_fpA got=%h exp=40a00000", fpA); end
      req = 2'b00;
      tick;
      doneFP = 1'b1; resultFP = 32'h4100_0000;
      tick;
      doneFP = 1'b0;
      total++; if (resultReady !== 2'b10) begin bad++; $display("FAIL t4_ready got=%b exp=10", resultReady); end
      resultAccepted = 2'b01;
      tick;
      total++; if (resultReady !== 2'b10) begin bad++; $display("FAIL t4_other_ack got=%b exp=10", resultReady); end
      resultAccepted = 2'b10;
      req = 2'b01;
      doneFP = 1'b1; resultFP = 32'hDEAD_BEEF;
      tick;
      for (int i = 0; i < 5; i++) begin
         total++; if (resultReady !== 2'b00 || busy !== 1'b1 || grant !== 2'b00)
            begin bad++; $display("FAIL t4_finish%0d got=rdy %b busy %b grant %b exp=00/1/00", i, resultReady, busy, grant); end
         if (i < 4) tick;
      end
      total++; if (outBus !== 32'h4100_0000) begin bad++; $display("FAIL t4_late_done got=%h exp=41000000", outBus); end
      doneFP = 1'b0;
      resultAccepted = 2'b00;
      tick;
      total++; if (busy !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL t4_idle got=busy %b grant %b exp=0/00", busy, grant); end
      tick;
      total++; if (grant !== 2'b01) begin bad++; $display("FAIL t4_next_grant got=%b exp=01", grant); end
      req = 2'b00;
      finish_op(2'b01, 32'h3F80_0000);
   endtask

   task automatic test_done_in_start;
      do_reset;
      opA = {32'h0, 32'h3F80_0000};
      opB = {32'h0, 32'h3F00_0000};
      req = 2'b01;
      tick;
      doneFP = 1'b1; resultFP = 32'h3FC0_0000; req = 2'b00;
      tick;
      doneFP = 1'b0;
      total++; if (resultReady !== 2'b01) begin bad++; $display("FAIL t_start_done_ready got=%b exp=01", resultReady); end
      total++; if (outBus !== 32'h3FC0_0000) begin bad++; $display("FAIL t_start_done_bus got=%h exp=3fc00000", outBus); end
      resultAccepted = 2'b01;
      tick;
      resultAccepted = 2'b00;
      tick;
      doneFP = 1'b1; resultFP = 32'h1111_1111;
      tick;
      doneFP = 1'b0;
      total++; if (outBus !== 32'h3FC0_0000 || busy !== 1'b0) begin bad++; $display("FAIL t_idle_done got=%h busy %b exp=3fc00000/0", outBus, busy); end
   endtask

   task automatic test_reset_in_wait;
      opA = {32'h0, 32'h4080_0000};
      opB = {32'h0, 32'h4090_0000};
      req = 2'b01;
      tick;
      req = 2'b00;
      tick;
      tick;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t5_pre_busy got=%b exp=1", busy); end
      rst = 1'b1;
      tick;
      total++; if (grant !== 2'b00 || startFP !== 1'b0 || resultReady !== 2'b00 || busy !== 1'b0)
         begin bad++; $display("FAIL t5_ctrl got=%b %b %b %b exp=00 0 00 0", grant, startFP, resultReady, busy); end
      total++; if (fpA !== 32'h0 || fpB !== 32'h0 || outBus !== 32'h0)
         begin bad++; $display("FAIL t5_data got=%h %h %h exp=0 0 0", fpA, fpB, outBus); end
      rst = 1'b0;
      doneFP = 1'b1; resultFP = 32'h1234_5678;
      tick;
      doneFP = 1'b0;
      total++; if (outBus !== 32'h0 || resultReady !== 2'b00 || busy !== 1'b0)
         begin bad++; $display("FAIL t5_late_done got=%h %b %b exp=0 00 0", outBus, resultReady, busy); end
   endtask

`ifdef FPARB_TIMEOUT_EN
   task automatic test_timeout;
      do_reset;
      req = 2'b01;
      tick;
      req = 2'b00;
      tick;
      for (int i = 0; i < 7; i++) begin
         total++; if (resultReady !== 2'b00) begin bad++; $display("FAIL t6_wait%0d got=%b exp=00", i, resultReady); end
         tick;
      end
      total++; if (resultReady !== 2'b00 || timeoutErr !== 1'b0) begin bad++; $display("FAIL t6_last_wait got=%b %b exp=00 0", resultReady, timeoutErr); end
      tick;
      total++; if (resultReady !== 2'b01) begin bad++; $display("FAIL t6_ready got=%b exp=01", resultReady); end
      total++; if (outBus !== 32'h7FC0_0000) begin bad++; $display("FAIL t6_nan got=%h exp=7fc00000", outBus); end
      total++; if (timeoutErr !== 1'b1) begin bad++; $display("FAIL t6_err got=%b exp=1", timeoutErr); end
      resultAccepted = 2'b01;
      tick;
      resultAccepted = 2'b00;
      tick;
      total++; if (timeoutErr !== 1'b1) begin bad++; $display("FAIL t6_err_hold got=%b exp=1", timeoutErr); end
      req = 2'b01;
      tick;
      req = 2'b00;
      total++; if (timeoutErr !== 1'b0) begin bad++; $display("FAIL t6_err_clear got=%b exp=0", timeoutErr); end
      finish_op(2'b01, 32'h4000_0000);
   endtask
`endif

   initial begin
      test_reset;
      test_single;
      test_simultaneous;
      test_back_to_back;
      test_finish_hold;
      test_done_in_start;
      test_reset_in_wait;
`ifdef FPARB_TIMEOUT_EN
      test_timeout;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Shares one IEEE-754 single-precision FP core among NREQ requesters using round-robin arbitration.
- Latches the winning requester's operand pair and pulses the core's start.
- Waits for doneFP, registers the result, and returns it to the owning requester over a 4-phase resultReady/resultAccepted handshake, the same handshake the FP output stage uses.
- Sits between the requester input wrappers and the FP core.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- W, 32, operand/result width in bits.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when FPARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  req[i]=1: requester i presents a valid operand pair.
- opA  in  NREQ*W  packed; requester i uses bits [i*W +: W].
- opB  in  NREQ*W  packed, same layout as opA.
- grant  out  NREQ  one-hot, one-cycle pulse; tells requester i that its operands were captured.
- startFP  out  1  one-cycle start pulse to the FP core.
- fpA  out  W  registered operand A to the core; stable from START until the next capture.
- fpB  out  W  registered operand B to the core; same stability rule.
- doneFP  in  1  core completion strobe.
- resultFP  in  W  core result; valid when doneFP=1.
- resultReady  out  NREQ  one-hot; result valid for that requester.
- resultAccepted  in  NREQ  per-requester acknowledge.
- outBus  out  W  registered result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE. grant, startFP, resultReady and busy = 0. fpA, fpB and outBus = 0. Round-robin pointer = 0, so requester 0 has highest priority.
- FSM states: IDLE, START, WAIT, DELIVER, FINISH. All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- IDLE:
  - If any req is set, pick the winner by searching from index ptr upward, modulo NREQ.
  - At the clock edge: fpA/fpB <= winner's operands, owner <= winner, ptr <= (winner+1) mod NREQ, state -> START.
  - If no req is set, stay in IDLE.
- START (exactly 1 cycle): grant[owner]=1 and startFP=1.
  - doneFP=1 in this cycle is accepted: handle as in WAIT, go to DELIVER.
  - Otherwise go to WAIT.
- WAIT: hold until doneFP=1. At that edge outBus <= resultFP, state -> DELIVER.
- DELIVER: resultReady[owner]=1.
  - resultAccepted[owner]=1 -> FINISH.
  - resultAccepted bits of other requesters are ignored.
- FINISH: resultReady=0. Stay until resultAccepted[owner]=0, then go to IDLE.
- Latency: req at cycle t, grant and startFP at t+1. A core that raises doneFP at cycle d shows resultReady from d+1.
- Requesters must drop req after grant. A req still high when the FSM returns to IDLE is treated as a new request.
- doneFP outside START/WAIT is ignored; no state change and outBus unchanged.
- The pointer advances only on capture, so a continuously asserted set of requests is serviced in strict rotation.
- outBus holds its last value until the next doneFP capture.
- Changes on req or opA/opB while busy have no effect.
- Reset in any state, including WAIT or DELIVER, abandons the operation: all outputs go to their reset values next cycle. A late doneFP from the abandoned operation is ignored because the FSM is in IDLE.

Optional Feature:
- FPARB_TIMEOUT_EN defined:
  - Add output timeoutErr (1 bit, reset 0) and a cycle counter that counts in WAIT.
  - If the counter reaches TIMEOUT_CYCLES without doneFP: outBus <= 32'h7FC00000 (quiet NaN), timeoutErr <= 1, state -> DELIVER.
  - timeoutErr clears on the next capture in IDLE.
  - The counter clears on entry to START.
- FPARB_TIMEOUT_EN undefined: no counter and no timeoutErr port; WAIT waits indefinitely.

Test Plan:
1. NREQ=2. req[0]=1 alone with opA=32'h3F800000, opB=32'h40000000. Expect grant[0] one cycle later, startFP in the same cycle, fpA/fpB equal to those operands. Core returns 32'h40400000 three cycles later. Expect resultReady[0]=1 with outBus=32'h40400000 until resultAccepted[0], then resultReady=0.
2. req[0] and req[1] rise in the same cycle after reset. Expect requester 0 served first. req[1] stays high, so it is served next with no intervening grant to 0.
3. Both req held high for 4 transactions. Expect grant order 0,1,0,1.
4. Hold resultAccepted[1] high for 5 cycles after DELIVER. Expect FINISH held 5 cycles, busy=1, and no new grant until resultAccepted falls.
5. Assert rst during WAIT, then pulse doneFP with 32'h12345678. Expect all outputs at reset values and outBus=0.
6. With FPARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, never assert doneFP. Expect outBus=32'h7FC00000, timeoutErr=1 and resultReady[owner]=1 after 8 WAIT cycles.
